ddr_line_ctrl: RTL
==================

DDR_LINE_CTRL -- requirements
Module: ddr_line_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 64, requester word width; legal values 32, 64, 128.
REQ-002 Parameter ADDR_WIDTH, default 64, requester address width.
REQ-003 Parameter APP_ADDR_WIDTH, default 27, DDR app address width.
REQ-004 Parameter GAP_CYCLES, default 4, idle cycles forced between transactions (0 legal).
REQ-005 Parameter TIMEOUT_CYCLES, default 1024, max cycles in any DDR wait state.
REQ-006 Parameter LINE_BUF_EN, default 1, enables the one-line read buffer.
REQ-007 One clock; reset is synchronous and active-low: ui_clk in 1, rising-edge clock for all logic; ui_clk_sync_rst_n in 1, synchronous active-low reset.
REQ-008 addr_mem in ADDR_WIDTH byte address; wdata_mem in DATA_WIDTH; wmask_mem in DATA_WIDTH/8, 1 = byte written.
REQ-009 wen_mem in 1, ren_mem in 1, level requests held until valid_mem.
REQ-010 rdata_mem out DATA_WIDTH; valid_mem out 1 done; err_mem out 1 timeout flag qualified by valid_mem.
REQ-011 app_addr out APP_ADDR_WIDTH; app_cmd out 3 (0 write, 1 read); app_en out 1; app_wdf_data out 128; app_wdf_mask out 16, 1 = byte masked; app_wdf_wren out 1; app_wdf_end out 1.
REQ-012 app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete in 1; app_rd_data in 128.
REQ-013 debug_state out 3, current FSM state; debug_hit out 1, pulses on line-buffer read hit.

Function
REQ-014 States: IDLE, CMD_WR, CMD_RD, WAIT_RD, DONE, GAP; no other reachable encodings.
REQ-015 LANES = 128/DATA_WIDTH; lane index = addr_mem[3:log2(DATA_WIDTH/8)] (0 when DATA_WIDTH=128); line tag = addr_mem[APP_ADDR_WIDTH-1:4].
REQ-016 IDLE starts nothing while init_calib_complete=0; requests stay pending.
REQ-017 IDLE, wen_mem=1: latch app_addr={tag,4'b0}, app_cmd=0, app_wdf_data=wdata_mem replicated LANES times, app_wdf_mask all ones except selected lane = ~wmask_mem, app_wdf_end=1; next cycle CMD_WR.
REQ-018 wen_mem and ren_mem both high in IDLE: write wins.
REQ-019 CMD_WR: app_en and app_wdf_wren asserted together; app_en drops the cycle after app_en&app_rdy; app_wdf_wren drops the cycle after app_wdf_wren&app_wdf_rdy; both accepted (any order, same cycle allowed) -> DONE.
REQ-020 IDLE, ren_mem=1, wen_mem=0, line-buffer valid with matching tag: no DDR command; rdata_mem=selected lane of buffer, valid_mem=1 next cycle (DONE), debug_hit=1 one cycle.
REQ-021 IDLE, ren_mem=1, miss: also blocked while app_rd_data_valid=1; latch app_addr, app_cmd=1, app_wdf_wren=0; -> CMD_RD.
REQ-022 CMD_RD: app_en=1 until app_en&app_rdy, then app_en=0 -> WAIT_RD.
REQ-023 WAIT_RD: first app_rd_data_valid captures selected lane into rdata_mem, fills buffer with full 128-bit line and tag, valid=1; -> DONE.
REQ-024 app_rd_data_valid outside WAIT_RD is ignored.
REQ-025 Write whose tag matches a valid buffer line merges wdata_mem into that buffer lane per wmask_mem at IDLE acceptance (write-through).
REQ-026 Timeout counter clears on entering CMD_WR/CMD_RD, counts in CMD_WR/CMD_RD/WAIT_RD; reaching TIMEOUT_CYCLES forces app_en=0, app_wdf_wren=0, rdata_mem=0, err_mem=1, buffer invalid, -> DONE.
REQ-027 DONE: valid_mem held 1 (and err_mem as set) until wen_mem=0 and ren_mem=0; then valid_mem=0, err_mem=0, -> GAP.
REQ-028 GAP: stays GAP_CYCLES cycles (0 = straight to IDLE), ignores requests.
REQ-029 Read latency: hit 1 cycle request-to-valid_mem; miss = 1 + app_rdy wait + DDR read latency + 1.
REQ-030 LINE_BUF_EN=0: every read is a miss, buffer never valid, debug_hit=0.

Reset
REQ-031 ui_clk_sync_rst_n=0 at a clock edge: state=IDLE, app_en=0, app_wdf_wren=0, app_wdf_end=0, app_cmd=1, app_addr=0, app_wdf_data=0, app_wdf_mask=0, rdata_mem=0, valid_mem=0, err_mem=0, debug_hit=0, buffer invalid, counters 0.
REQ-032 Reset mid-transaction aborts immediately with REQ-031 values; later stray app_rd_data_valid ignored per REQ-024.

Verification
REQ-033 DATA_WIDTH=64, write addr 0x108, wdata 0x1122334455667788, wmask 0x0F -> app_addr 0x100, app_wdf_mask 0xF0FF, data replicated, valid_mem after both accepts.
REQ-034 Read miss 0x108, app_rd_data {64'hAAAA..., 64'h5555...} -> rdata_mem 0xAAAAAAAAAAAAAAAA; repeat read 0x100 -> no app_en, rdata 0x5555555555555555 one cycle, debug_hit=1.
REQ-035 After REQ-034, write 0x100 wmask 0xFF data 0x0 then read 0x100 -> hit returns 0x0.
REQ-036 app_rdy held 0, TIMEOUT_CYCLES=16 -> app_en drops, valid_mem=1, err_mem=1, rdata_mem=0 at cycle 16.
REQ-037 wen_mem=ren_mem=1 with init_calib_complete=0 for 10 cycles -> no app_en; on calib=1 write issued first.
REQ-038 Reset asserted in WAIT_RD, then app_rd_data_valid -> outputs at reset values, valid_mem stays 0.

Source files
------------

// File: rtl/ddr_line_ctrl_if.sv
// Requester and DDR app-side signal bundle for ddr_line_ctrl.
// slave is the controller's view, master is the requester/DDR model's view.
interface ddr_line_ctrl_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int APP_ADDR_WIDTH = 27
);
    logic [ADDR_WIDTH-1:0]     addr_mem;
    logic [DATA_WIDTH-1:0]     wdata_mem;
    logic [DATA_WIDTH/8-1:0]   wmask_mem;
    logic                      wen_mem;
    logic                      ren_mem;
    logic [DATA_WIDTH-1:0]     rdata_mem;
    logic                      valid_mem;
    logic                      err_mem;

    logic [APP_ADDR_WIDTH-1:0] app_addr;
    logic [2:0]                app_cmd;
    logic                      app_en;
    logic [127:0]              app_wdf_data;
    logic [15:0]               app_wdf_mask;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic                      app_rdy;
    logic                      app_wdf_rdy;
    logic                      app_rd_data_valid;
    logic                      app_rd_data_end;
    logic [127:0]              app_rd_data;
    logic                      init_calib_complete;

    logic [2:0]                debug_state;
    logic                      debug_hit;

    modport slave (
        input  addr_mem, wdata_mem, wmask_mem, wen_mem, ren_mem,
        input  app_rdy, app_wdf_rdy, app_rd_data_valid,
        input  app_rd_data_end, app_rd_data, init_calib_complete,
        output rdata_mem, valid_mem, err_mem,
        output app_addr, app_cmd, app_en, app_wdf_data,
        output app_wdf_mask, app_wdf_wren, app_wdf_end,
        output debug_state, debug_hit
    );

    modport master (
        output addr_mem, wdata_mem, wmask_mem, wen_mem, ren_mem,
        output app_rdy, app_wdf_rdy, app_rd_data_valid,
        output app_rd_data_end, app_rd_data, init_calib_complete,
        input  rdata_mem, valid_mem, err_mem,
        input  app_addr, app_cmd, app_en, app_wdf_data,
        input  app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  debug_state, debug_hit
    );
endinterface

// File: rtl/ddr_line_ctrl.sv
// Narrow requester to 128-bit DDR app bridge with a one-line
// write-through read buffer and per-transaction timeout.
module ddr_line_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int APP_ADDR_WIDTH = 27,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LINE_BUF_EN    = 1
) (
    input logic             ui_clk,
    input logic             ui_clk_sync_rst_n,
    ddr_line_ctrl_if.slave  bus
);
    localparam int LANES = 128 / DATA_WIDTH;
    localparam int MB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(MB);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TAGW  = APP_ADDR_WIDTH - 4;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD_WR  = 3'd1,
        S_CMD_RD  = 3'd2,
        S_WAIT_RD = 3'd3,
        S_DONE    = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t                    r_state;
    logic                      r_app_en;
    logic                      r_wren;
    logic                      r_wdf_end;
    logic [2:0]                r_cmd;
    logic [APP_ADDR_WIDTH-1:0] r_addr;
    logic [127:0]              r_wdata;
    logic [15:0]               r_mask;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_valid;
    logic                      r_err;
    logic                      r_hit;
    logic                      r_buf_valid;
    logic [TAGW-1:0]           r_buf_tag;
    logic [127:0]              r_buf_data;
    logic [TW-1:0]             r_to_cnt;
    logic [GW-1:0]             r_gap_cnt;

    logic [LW-1:0]             w_lane;
    logic [TAGW-1:0]           w_tag;
    logic [15:0]               w_wdf_mask;
    logic [127:0]              w_merge;
    logic [DATA_WIDTH-1:0]     w_buf_lane;
    logic [DATA_WIDTH-1:0]     w_rd_lane;
    logic                      w_hit;
    logic                      w_wait;
    logic                      w_to;
    logic                      w_unused;

    generate
        if (LANES > 1) begin : g_lane
            assign w_lane = bus.addr_mem[3:LSB];
        end else begin : g_nolane
            assign w_lane = 1'b0;
        end
    endgenerate

    assign w_tag    = bus.addr_mem[APP_ADDR_WIDTH-1:4];
    assign w_hit    = (LINE_BUF_EN != 0) && r_buf_valid &&
                      (r_buf_tag == w_tag);
    assign w_wait   = (r_state == S_CMD_WR) || (r_state == S_CMD_RD) ||
                      (r_state == S_WAIT_RD);
    assign w_to     = int'(r_to_cnt) >= TIMEOUT_CYCLES - 1;
    assign w_unused = ^{bus.addr_mem, bus.app_rd_data_end};

    always_comb begin
        w_wdf_mask = '1;
        w_merge    = r_buf_data;
        w_buf_lane = '0;
        w_rd_lane  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_lane == LW'(i)) begin
                w_wdf_mask[i*MB +: MB] = ~bus.wmask_mem;
                w_buf_lane = r_buf_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_rd_lane  = bus.app_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                for (int b = 0; b < MB; b++) begin
                    if (bus.wmask_mem[b])
                        w_merge[i*DATA_WIDTH + b*8 +: 8] =
                            bus.wdata_mem[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (!ui_clk_sync_rst_n) begin
            r_state     <= S_IDLE;
            r_app_en    <= 1'b0;
            r_wren      <= 1'b0;
            r_wdf_end   <= 1'b0;
            r_cmd       <= 3'd1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_rdata     <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_hit       <= 1'b0;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_hit <= 1'b0;
            if (w_wait && w_to) begin
                // abandon the DDR exchange and report an error
                r_app_en    <= 1'b0;
                r_wren      <= 1'b0;
                r_rdata     <= '0;
                r_err       <= 1'b1;
                r_valid     <= 1'b1;
                r_buf_valid <= 1'b0;
                r_state     <= S_DONE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (!bus.init_calib_complete) begin
                            r_state <= S_IDLE;
                        end else if (bus.wen_mem) begin
                            r_addr    <= {w_tag, 4'b0000};
                            r_cmd     <= 3'd0;
                            r_wdata   <= {LANES{bus.wdata_mem}};
                            r_mask    <= w_wdf_mask;
                            r_wdf_end <= 1'b1;
                            r_app_en  <= 1'b1;
                            r_wren    <= 1'b1;
                            r_to_cnt  <= '0;
                            if (w_hit)
                                r_buf_data <= w_merge;
                            r_state   <= S_CMD_WR;
                        end else if (bus.ren_mem && w_hit) begin
                            r_rdata <= w_buf_lane;
                            r_valid <= 1'b1;
                            r_hit   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (bus.ren_mem &&
                                     !bus.app_rd_data_valid) begin
                            r_addr   <= {w_tag, 4'b0000};
                            r_cmd    <= 3'd1;
                            r_wren   <= 1'b0;
                            r_app_en <= 1'b1;
                            r_to_cnt <= '0;
                            r_state  <= S_CMD_RD;
                        end
                    end
                    S_CMD_WR: begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                        if (r_app_en && bus.app_rdy)
                            r_app_en <= 1'b0;
                        if (r_wren && bus.app_wdf_rdy)
                            r_wren <= 1'b0;
                        if ((!r_app_en || bus.app_rdy) &&
                            (!r_wren || bus.app_wdf_rdy)) begin
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_CMD_RD: begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                        if (bus.app_rdy) begin
                            r_app_en <= 1'b0;
                            r_state  <= S_WAIT_RD;
                        end
                    end
                    S_WAIT_RD: begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                        if (bus.app_rd_data_valid) begin
                            r_rdata <= w_rd_lane;
                            r_valid <= 1'b1;
                            if (LINE_BUF_EN != 0) begin
                                r_buf_valid <= 1'b1;
                                r_buf_tag   <= r_addr[APP_ADDR_WIDTH-1:4];
                                r_buf_data  <= bus.app_rd_data;
                            end
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (!bus.wen_mem && !bus.ren_mem) begin
                            r_valid   <= 1'b0;
                            r_err     <= 1'b0;
                            r_gap_cnt <= '0;
                            r_state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (int'(r_gap_cnt) >= GAP_CYCLES - 1)
                            r_state <= S_IDLE;
                        else
                            r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.app_addr     = r_addr;
    assign bus.app_cmd      = r_cmd;
    assign bus.app_en       = r_app_en;
    assign bus.app_wdf_data = r_wdata;
    assign bus.app_wdf_mask = r_mask;
    assign bus.app_wdf_wren = r_wren;
    assign bus.app_wdf_end  = r_wdf_end;
    assign bus.rdata_mem    = r_rdata;
    assign bus.valid_mem    = r_valid;
    assign bus.err_mem      = r_err;
    assign bus.debug_state  = r_state;
    assign bus.debug_hit    = r_hit;
endmodule
